// File: rtl/dword_mem_port.sv
// Splits one 64-bit load/store into two 32-bit beats on a 1-cycle-latency RAM port, then pulses a response.
// Define DWORD_MEM_ALIGN_CHECK_EN to reject misaligned requests with rsp_err; otherwise addresses are force-aligned.
`timescale 1ns/1ps
module dword_mem_port (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [63:0] rsp_rdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [63:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, B0, B1, B2, DONE} state_t;

    state_t      state;
    logic        wr_q;
    logic [63:0] addr_q;
    logic [31:0] wdata_hi_q;
    logic [63:0] addr_aligned;
    logic        misaligned;

    assign addr_aligned = req_addr & ~64'h7;

`ifdef DWORD_MEM_ALIGN_CHECK_EN
    assign misaligned = (req_addr[2:0] != 3'b000);
`else
    assign misaligned = 1'b0;
    assign rsp_err    = 1'b0;
`endif

    // Outputs are registered one state ahead so every mem_*/rsp_* value lines up with the state it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 64'd0;
            mem_en     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= 64'd0;
            mem_wdata  <= 32'd0;
            wr_q       <= 1'b0;
            addr_q     <= 64'd0;
            wdata_hi_q <= 32'd0;
`ifdef DWORD_MEM_ALIGN_CHECK_EN
            rsp_err    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr_q       <= req_write;
                        addr_q     <= addr_aligned;
                        wdata_hi_q <= req_wdata[63:32];
                        req_ready  <= 1'b0;
`ifdef DWORD_MEM_ALIGN_CHECK_EN
                        rsp_err    <= misaligned;
`endif
                        if (misaligned) begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                        end else begin
                            state     <= B0;
                            mem_en    <= 1'b1;
                            mem_wr    <= req_write;
                            mem_addr  <= addr_aligned;
                            mem_wdata <= req_wdata[31:0];
                        end
                    end
                end
                B0: begin
                    state     <= B1;
                    mem_addr  <= addr_q + 64'd4;
                    mem_wdata <= wdata_hi_q;
                end
                B1: begin
                    mem_en    <= 1'b0;
                    mem_wr    <= 1'b0;
                    mem_addr  <= 64'd0;
                    mem_wdata <= 32'd0;
                    if (!wr_q) begin
                        // RAM answers the B0 read during B1
                        rsp_rdata[31:0] <= mem_rdata;
                        state           <= B2;
                    end else begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                    end
                end
                B2: begin
                    rsp_rdata[63:32] <= mem_rdata;
                    state            <= DONE;
                    rsp_valid        <= 1'b1;
                end
                DONE: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
`ifdef DWORD_MEM_ALIGN_CHECK_EN
                    rsp_err   <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dword_mem_port.sv
// Randomized scoreboard bench for dword_mem_port with a word-array reference model and a 1-cycle RAM.
`timescale 1ns/1ps
module tb_dword_mem_port;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [63:0] rsp_rdata;
    logic        mem_en;
    logic        mem_wr;
    logic [63:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'hDEAD_BEEF;

    always #5 clk = ~clk;

    dword_mem_port dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    typedef struct packed {
        logic [63:0] addr;
        logic        wr;
        logic [31:0] wdata;
    } beat_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic        err;
        logic [63:0] rdata;
    } rsp_t;

    beat_t beat_q[$];
    rsp_t  rsp_q[$];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_acc = 0;
    int          last_int = 0;
    logic [63:0] last_rdata = 64'd0;
    logic [31:0] ref_mem [0:1023];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event missing or unexpected at cycle %0d", name, cyc);
    endtask

    // RAM aliases on address bits [11:2]; the model uses the same map.
    function automatic logic [9:0] idx(input logic [63:0] a);
        return a[11:2];
    endfunction

    function automatic logic [31:0] init_word(input logic [9:0] i);
        if (i == 10'd64) return 32'h1122_3344;
        if (i == 10'd65) return 32'hAABB_CCDD;
        return 32'h5A00_0000 ^ ({22'd0, i} * 32'h9E37_79B1);
    endfunction

    bit [31:0] ram [0:1023];
    bit        written [0:1023];

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        mem_rdata <= 32'hDEAD_BEEF;
        if (mem_en) begin
            if (mem_wr) begin
                ram[idx(mem_addr)]     <= mem_wdata;
                written[idx(mem_addr)] <= 1'b1;
            end else begin
                mem_rdata <= written[idx(mem_addr)] ? ram[idx(mem_addr)] : init_word(idx(mem_addr));
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (mem_en) begin
                if (beat_q.size() == 0) fail_now("unexpected_beat");
                else begin
                    beat_t b;
                    b = beat_q.pop_front();
                    check("beat_addr", mem_addr, b.addr);
                    check("beat_wr", {63'd0, mem_wr}, {63'd0, b.wr});
                    if (b.wr) check("beat_wdata", {32'd0, mem_wdata}, {32'd0, b.wdata});
                end
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) fail_now("unexpected_rsp");
                else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    check("rsp_cycle", 64'(cyc), {32'd0, r.cyc});
                    check("rsp_err", {63'd0, rsp_err}, {63'd0, r.err});
                    check("rsp_rdata", rsp_rdata, r.rdata);
                end
            end
        end
    end

    // Call at a negedge; returns at the negedge right after the accept edge.
    task automatic send(input logic w, input logic [63:0] a, input logic [63:0] d, input bit b2b);
        int          waited;
        int          acc;
        logic        err;
        logic [63:0] ea;
        rsp_t        r;
        waited    = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        while (req_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (req_ready !== 1'b1) begin
            fail_now("accept_timeout");
            req_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        if (b2b) check("accept_gap", 64'(acc - last_acc), 64'(last_int));
`ifdef DWORD_MEM_ALIGN_CHECK_EN
        err = (a[2:0] != 3'b000);
`else
        err = 1'b0;
`endif
        ea      = a & ~64'h7;
        r.err   = err;
        r.rdata = last_rdata;
        if (err) begin
            r.cyc    = 32'(acc);
            last_int = 2;
        end else if (w) begin
            beat_q.push_back('{addr: ea, wr: 1'b1, wdata: d[31:0]});
            beat_q.push_back('{addr: ea + 64'd4, wr: 1'b1, wdata: d[63:32]});
            ref_mem[idx(ea)]         = d[31:0];
            ref_mem[idx(ea + 64'd4)] = d[63:32];
            r.cyc    = 32'(acc + 2);
            last_int = 4;
        end else begin
            beat_q.push_back('{addr: ea, wr: 1'b0, wdata: 32'd0});
            beat_q.push_back('{addr: ea + 64'd4, wr: 1'b0, wdata: 32'd0});
            last_rdata = {ref_mem[idx(ea + 64'd4)], ref_mem[idx(ea)]};
            r.rdata    = last_rdata;
            r.cyc      = 32'(acc + 3);
            last_int   = 5;
        end
        rsp_q.push_back(r);
        last_acc = acc;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          waited;
        int          gap;
        bit          b2b;
        logic        w;
        logic [63:0] a;
        logic [63:0] d;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(10'(i));

        repeat (3) @(negedge clk);
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
        check("rst_mem_en", {63'd0, mem_en}, 64'd0);
        check("rst_mem_wr", {63'd0, mem_wr}, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
        check("rst_rsp_rdata", rsp_rdata, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        send(1'b0, 64'h100, 64'h0, 1'b0);                       idle(2);
        send(1'b1, 64'h200, 64'h0123_4567_89AB_CDEF, 1'b0);     idle(1);
        send(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 1'b0);       idle(1);
        send(1'b0, 64'h105, 64'h0, 1'b0);                       idle(1);
        send(1'b1, 64'h300, 64'hCAFE_F00D_1234_5678, 1'b0);
        send(1'b0, 64'h300, 64'h0, 1'b1);                       idle(2);

        // Abort a load in its second beat
        send(1'b0, 64'h308, 64'h0, 1'b0);
        req_valid = 1'b0;
        waited = 0;
        while (!(mem_en === 1'b1 && mem_addr === 64'h30C) && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 10) fail_now("b1_timeout");
        #1 reset = 1'b0;
        #1;
        check("abort_req_ready", {63'd0, req_ready}, 64'd1);
        check("abort_mem_en", {63'd0, mem_en}, 64'd0);
        check("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("abort_mem_addr", mem_addr, 64'd0);
        check("abort_rsp_rdata", rsp_rdata, 64'd0);
        rsp_q.delete();
        beat_q.delete();
        last_rdata = 64'd0;
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);

        b2b = 1'b0;
        for (int n = 0; n < 60; n++) begin
            w = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       a = 64'hFFFF_FFFF_FFFF_FFF8;
                1:       a = 64'h100;
                default: a = 64'($urandom_range(0, 511)) << 3;
            endcase
            if ($urandom_range(0, 4) == 0) a = a + 64'($urandom_range(1, 7));
            d = {$urandom, $urandom};
            send(w, a, d, b2b);
            gap = $urandom_range(0, 2);
            if (gap != 0) idle(gap);
            b2b = (gap == 0);
        end
        req_valid = 1'b0;

        waited = 0;
        while ((rsp_q.size() != 0 || beat_q.size() != 0) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (rsp_q.size() != 0 || beat_q.size() != 0) fail_now("drain_timeout");
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
